// File: rtl/spi_ram_master.sv
// Host-side SPI master that turns valid/ready RAM requests into two-frame SPI command sequences.
// Optional address-skip cache enabled by defining SPI_RAM_MASTER_ADDR_SKIP_EN.
module spi_ram_master #(
    parameter int IDLE_GAP = 1,
    parameter int RD_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FRAME1  = 3'd1,
        S_GAP     = 3'd2,
        S_FRAME2  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_CAP  = 3'd5,
        S_RESP    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  shift_q;
    logic        ss_q, ss_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept_s;
    logic        is_rd_s;
    logic        illegal_s;
    logic        hit_s;
    logic [10:0] f1_s;
    logic [10:0] f2_s;

    assign accept_s  = (state_q == S_IDLE) && req_valid && ready_q;
    assign is_rd_s   = (op_q == 2'b10);
    assign illegal_s = op_q[0];

    // Each frame is {selector, cmd[1:0], payload[7:0]}, shifted out MSB first.
    assign f1_s = {is_rd_s, is_rd_s, 1'b0, addr_q};
    assign f2_s = {is_rd_s, is_rd_s, 1'b1, (is_rd_s ? 8'h00 : wdata_q)};

`ifdef SPI_RAM_MASTER_ADDR_SKIP_EN
    logic       wr_v_q, wr_v_d;
    logic       rd_v_q, rd_v_d;
    logic [7:0] wr_a_q, wr_a_d;
    logic [7:0] rd_a_q, rd_a_d;

    assign hit_s = ((req_op == 2'b00) && wr_v_q && (wr_a_q == req_addr)) ||
                   ((req_op == 2'b10) && rd_v_q && (rd_a_q == req_addr));

    // Address cache next-state: filled when FRAME1 completes, dropped by an illegal op.
    always_comb begin
        wr_v_d = wr_v_q;
        rd_v_d = rd_v_q;
        wr_a_d = wr_a_q;
        rd_a_d = rd_a_q;
        if (state_q == S_FRAME1) begin
            if (illegal_s) begin
                wr_v_d = 1'b0;
                rd_v_d = 1'b0;
            end else if (cnt_q == 4'd10) begin
                if (is_rd_s) begin
                    rd_v_d = 1'b1;
                    rd_a_d = addr_q;
                end else begin
                    wr_v_d = 1'b1;
                    wr_a_d = addr_q;
                end
            end else begin
                wr_v_d = wr_v_q;
            end
        end else begin
            wr_v_d = wr_v_q;
        end
    end

    // Address cache registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v_q <= 1'b0;
            rd_v_q <= 1'b0;
            wr_a_q <= 8'h00;
            rd_a_q <= 8'h00;
        end else begin
            wr_v_q <= wr_v_d;
            rd_v_q <= rd_v_d;
            wr_a_q <= wr_a_d;
            rd_a_q <= rd_a_d;
        end
    end
`else
    assign hit_s = 1'b0;
`endif

    // Next-state and registered-output decode; outputs appear one edge after the state that drives them.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ss_d        = 1'b1;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_d   = 4'd0;
                    state_d = (hit_s && !req_op[0]) ? S_FRAME2 : S_FRAME1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FRAME1: begin
                if (illegal_s) begin
                    state_d = S_RESP;
                end else begin
                    ss_d   = 1'b0;
                    mosi_d = f1_s[4'd10 - cnt_q];
                    if (cnt_q == 4'd10) begin
                        cnt_d   = 4'd0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == 4'(IDLE_GAP - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = S_FRAME2;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_FRAME2: begin
                ss_d   = 1'b0;
                mosi_d = f2_s[4'd10 - cnt_q];
                if (cnt_q == 4'd10) begin
                    cnt_d   = 4'd0;
                    state_d = is_rd_s ? S_RD_WAIT : S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_WAIT: begin
                ss_d = 1'b0;
                if (cnt_q == 4'(RD_GAP - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = S_RD_CAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_CAP: begin
                ss_d = 1'b0;
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // Ready only while settled in IDLE, so it rises the cycle after the response pulse.
        ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
    end

    // State, counter and serial/handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Request latch, MISO capture shift register and held response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= 2'b00;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            shift_q     <= 8'h00;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept_s) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == S_RD_CAP) begin
                shift_q <= {shift_q[6:0], MISO};
            end
            if (state_q == S_RESP) begin
                rsp_err_q   <= illegal_s;
                rsp_rdata_q <= is_rd_s ? shift_q : 8'h00;
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign SS_n      = ss_q;
    assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Scoreboard bench for spi_ram_master: reference RAM model plus an SPI slave model on the serial pins.
module tb_spi_ram_master;

    localparam int G = 1;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    spi_ram_master #(.IDLE_GAP(G), .RD_GAP(R)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [7:0] rdata; logic err; } rsp_t;
    typedef struct { logic [10:0] bits; int len; bit first; } frm_t;

    rsp_t rsp_q[$];
    frm_t frm_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int last_rsp_cyc = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] slv_mem [256];
    logic [7:0] slv_wr_a = 8'h00;
    logic [7:0] slv_rd_a = 8'h00;
    bit         m_wr_v = 1'b0;
    bit         m_rd_v = 1'b0;
    logic [7:0] m_wr_a = 8'h00;
    logic [7:0] m_rd_a = 8'h00;

    bit          in_frame = 1'b0;
    int          low_n = 0;
    int          high_n = 100;
    int          gap_fall = 0;
    logic [10:0] bits = 11'd0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        rsp_t r;
        frm_t f;
        bit   hit;
        bit   rd;
        if (op[0]) begin
            r.due = cyc + 2; r.rdata = 8'h00; r.err = 1'b1;
            rsp_q.push_back(r);
            m_wr_v = 1'b0;
            m_rd_v = 1'b0;
        end else begin
            rd  = op[1];
            hit = 1'b0;
`ifdef SPI_RAM_MASTER_ADDR_SKIP_EN
            hit = rd ? (m_rd_v && m_rd_a == a) : (m_wr_v && m_wr_a == a);
`endif
            if (!hit) begin
                f.bits = {rd, rd, 1'b0, a}; f.len = 11; f.first = 1'b1;
                frm_q.push_back(f);
            end
            f.bits  = {rd, rd, 1'b1, (rd ? 8'h00 : d)};
            f.len   = rd ? (11 + R + 8) : 11;
            f.first = hit;
            frm_q.push_back(f);
            r.err = 1'b0;
            if (rd) begin
                r.rdata = ref_mem[a];
                r.due   = cyc + (hit ? (20 + R) : (31 + G + R));
                m_rd_v = 1'b1; m_rd_a = a;
            end else begin
                ref_mem[a] = d;
                r.rdata = 8'h00;
                r.due   = cyc + (hit ? 12 : (23 + G));
                m_wr_v = 1'b1; m_wr_a = a;
            end
            rsp_q.push_back(r);
        end
    endtask

    // Cycle count and request acceptance; pushes expectations into the scoreboard.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && req_valid && req_ready) begin
            acc_cnt = acc_cnt + 1;
            acc_cyc = cyc;
            model_accept(req_op, req_addr, req_wdata);
        end
    end

    task automatic frame_end();
        frm_t f;
        if (frm_q.size() == 0) begin
            check_eq("frame_unexpected", {21'd0, bits}, 32'hFFFF_FFFF);
        end else begin
            f = frm_q.pop_front();
            check_eq("frame_bits", {21'd0, bits}, {21'd0, f.bits});
            check_eq("frame_len", low_n, f.len);
            if (f.first) check_eq("ss_high_min2", (gap_fall >= 2), 1);
            else         check_eq("ss_gap", gap_fall, G);
        end
        case (bits[10:8])
            3'b000:  slv_wr_a = bits[7:0];
            3'b001:  slv_mem[slv_wr_a] = bits[7:0];
            3'b110:  slv_rd_a = bits[7:0];
            default: slv_rd_a = slv_rd_a;
        endcase
    endtask

    // Response checker and SPI slave model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0; low_n = 0; high_n = 100; MISO = 1'b0;
        end else begin
            if (rsp_valid) begin
                last_rsp_cyc = cyc;
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", {23'd0, rsp_err, rsp_rdata}, 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check_eq("rsp_cycle", cyc, e.due);
                    check_eq("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
                    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
            if (!SS_n) begin
                if (!in_frame) begin
                    in_frame = 1'b1; low_n = 0; gap_fall = high_n; bits = 11'd0;
                end
                if (low_n < 11) bits = {bits[9:0], MOSI};
                else            check_eq("mosi_tail_low", {31'd0, MOSI}, 32'd0);
                low_n = low_n + 1;
                if (bits[10] && bits[9:8] == 2'b11 && low_n >= 11 + R && low_n < 19 + R)
                    MISO = slv_mem[slv_rd_a][7 - (low_n - 11 - R)];
                else
                    MISO = 1'b0;
            end else begin
                if (in_frame) begin
                    frame_end();
                    in_frame = 1'b0;
                    high_n = 1;
                end else begin
                    high_n = high_n + 1;
                end
                MISO = 1'b0;
                check_eq("mosi_ss_high", {31'd0, MOSI}, 32'd0);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        int start;
        start = acc_cnt;
        @(negedge clk);
        req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 300 && acc_cnt == start; i++) @(negedge clk);
        check_eq("accept_seen", (acc_cnt != start), 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (rsp_q.size() != 0 || frm_q.size() != 0); i++) @(negedge clk);
        check_eq("drain_done", rsp_q.size() + frm_q.size(), 0);
    endtask

    task automatic wait_accept(input int start);
        for (int i = 0; i < 300 && acc_cnt == start; i++) @(negedge clk);
        check_eq("accept_b2b", (acc_cnt != start), 1);
    endtask

    initial begin
        int first_rsp;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i) ^ 8'h5A;
            slv_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 8'h00; req_wdata = 8'h00; MISO = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check_eq("rst_mosi", {31'd0, MOSI}, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
        rst_n = 1'b1;
        #1 check_eq("ready_at_release", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq("ready_after_release", {31'd0, req_ready}, 32'd1);

        send(2'b00, 8'h3C, 8'hA5);
        drain();
        send(2'b10, 8'h3C, 8'h00);
        drain();
        send(2'b01, 8'h20, 8'h55);
        drain();
        send(2'b11, 8'h21, 8'h66);
        drain();
        send(2'b00, 8'hFF, 8'hFF);
        drain();
        send(2'b10, 8'hFF, 8'h00);
        drain();

        // Two reads with req_valid held high across the first transaction.
        @(negedge clk);
        req_op = 2'b10; req_addr = 8'h3C; req_valid = 1'b1;
        wait_accept(acc_cnt);
        req_addr = 8'h07;
        first_rsp = acc_cnt;
        wait_accept(first_rsp);
        req_valid = 1'b0;
        check_eq("b2b_accept_after_resp", acc_cyc - last_rsp_cyc, 2);
        drain();

        // Reset during bit 5 of FRAME2 of a write.
        send(2'b00, 8'h77, 8'h12);
        while (cyc < acc_cyc + 12 + G + 5) @(negedge clk);
        check_eq("ss_low_before_abort", {31'd0, SS_n}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check_eq("abort_ss_n", {31'd0, SS_n}, 32'd1);
        check_eq("abort_mosi", {31'd0, MOSI}, 32'd0);
        repeat (2) @(negedge clk);
        rsp_q.delete(); frm_q.delete();
        m_wr_v = 1'b0; m_rd_v = 1'b0;
        rst_n = 1'b1;
        #1 check_eq("ready_at_release2", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check_eq("ready_after_release2", {31'd0, req_ready}, 32'd1);
        repeat (40) @(negedge clk);

        send(2'b00, 8'h10, 8'h11);
        drain();
        send(2'b00, 8'h10, 8'h22);
        drain();
        send(2'b10, 8'h10, 8'h00);
        drain();

        for (int k = 0; k < 6; k++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)) + 8'h40, 8'($urandom));
            drain();
        end
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- Host-side SPI master that sequences complete RAM transactions over the single-slave SPI link of the SPI/RAM wrapper.
- A simple valid/ready host request is turned into the two-frame command sequence the slave/RAM expects:
  - write: write-address frame, then write-data frame.
  - read: read-address frame, then read-data frame, then 8-bit MISO capture.
- Serves as the on-chip driver for the wrapper and as the reusable stimulus master for system-level tests.

Parameters:
- IDLE_GAP, 1: cycles SS_n is held high between the two frames of one transaction (legal range 1-15).
- RD_GAP, 2: cycles after the last read-data command bit before MISO bit 7 is sampled (range 1-7).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  master can accept a request.
- req_op  input  2  2'b00 write, 2'b10 read; any other value is an error.
- req_addr  input  8  RAM address.
- req_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  8  read data; valid with rsp_valid.
- rsp_err  output  1  unsupported op; valid with rsp_valid.
- SS_n  output  1  slave select, active low, registered.
- MOSI  output  1  serial data to slave, registered.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (async) values:
  - SS_n=1, MOSI=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - State forced to IDLE.
  - req_ready rises the first cycle after rst_n deasserts.
  - Reset mid-frame aborts the transaction; no response is issued.
- States: IDLE, FRAME1, GAP, FRAME2, RD_WAIT, RD_CAP, RESP.
- IDLE:
  - req_ready=1; accept on req_valid&&req_ready at edge T.
  - Latch op, addr and wdata; go to FRAME1.
  - req_ready=0 in every other state.
- Illegal op: accepted, then RESP on the next cycle with rsp_err=1, rsp_rdata=0. No SPI activity.
- Frame format, 11 bits, one bit per cycle:
  - Bit 0 is the selector: 0 for write frames, 1 for read frames.
  - Then the 10-bit word MSB first: {cmd[1:0], payload[7:0]}.
  - SS_n falls on the same edge that drives the selector bit; MOSI changes only on rising edges.
  - bit_cnt counts 0..10.
- Command words:
  - FRAME1 write: {00, addr}. FRAME1 read: {10, addr}.
  - FRAME2 write: {01, wdata}. FRAME2 read: {11, 8'h00}.
- Timing after accept at T:
  - FRAME1 occupies T+1..T+11.
  - GAP holds SS_n=1, MOSI=0 for IDLE_GAP cycles.
  - FRAME2 occupies the next 11 cycles.
- Write completion:
  - SS_n rises and RESP is entered right after FRAME2.
  - rsp_valid arrives at T+23+IDLE_GAP (T+24 at default).
- Read completion:
  - After FRAME2, hold SS_n=0, MOSI=0 for RD_GAP cycles (RD_WAIT).
  - RD_CAP then shifts MISO into a shift register on 8 consecutive edges, first bit = rdata[7].
  - SS_n rises on the edge after the 8th sample.
  - rsp_valid arrives at T+31+IDLE_GAP+RD_GAP (T+34 at default).
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_err hold their values until the next RESP.
  - Return to IDLE, with req_ready=1 in the cycle after the pulse.
- Boundary conditions:
  - No back-to-back overlap: minimum SS_n-high time between transactions is 2 cycles (RESP + IDLE).
  - req_valid held high while busy is ignored and not lost; it is accepted in IDLE.
  - Address 8'hFF and data 8'hFF are sent unmodified.
  - bit_cnt never wraps within a frame.

Optional Feature:
- Macro: SPI_RAM_MASTER_ADDR_SKIP_EN.
- When defined:
  - Keep last_wr_addr/last_rd_addr, each with a valid flag. Flags are cleared by reset and by an illegal op.
  - If a write (or read) request's address equals the valid cached address of the same type, skip FRAME1 and GAP and start FRAME2 at T+1.
  - Write latency becomes 12; read latency becomes 20+RD_GAP.
  - The cache updates when FRAME1 completes.
- When undefined: both frames are always sent; latencies as above.

Test Plan:
- Write addr 8'h3C data 8'hA5 -> MOSI frames 0_00_00111100 then 0_01_10100101; rsp_valid at T+24, rsp_err=0.
- Read addr 8'h3C, slave model returns 8'hA5 on MISO -> frames 1_10_00111100, 1_11_00000000; rsp_valid at T+34 with rsp_rdata=8'hA5.
- req_op=2'b01 -> rsp_valid at T+2 with rsp_err=1; SS_n stays 1 throughout.
- Assert rst_n=0 at bit 5 of FRAME2 -> SS_n=1 and MOSI=0 immediately; no rsp_valid; req_ready=1 one cycle after release.
- req_valid held high for two reads -> second accepted only after RESP; SS_n high for at least 2 cycles between transactions.
- With SPI_RAM_MASTER_ADDR_SKIP_EN: write addr 8'h10 twice -> second transaction sends only FRAME2 and rsp_valid at T+12; without the macro -> T+24.
